// File: rtl/cpu_load_writeback_pkg.sv
// Shared CPU constants for the writeback stage: load size codes, writeback
// source selects, FSM state encoding and the load legality check.
package cpu_load_writeback_pkg;

    // funct3 load size/sign codes
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LD  = 3'b011;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] LWU = 3'b110;

    // writeback source selects (2'b11 is reserved)
    localparam logic [1:0] ALUOUT_SEL  = 2'b00;
    localparam logic [1:0] PC_P_4_SEL  = 2'b01;
    localparam logic [1:0] DTAMEM_SEL  = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } wb_state_t;

    // True when a load of this size at this byte offset cannot be performed:
    // misaligned for its size, or a size the datapath width does not support.
    function automatic logic load_is_faulty(input logic [2:0] f3,
                                            input logic [2:0] offs,
                                            input logic       rv64);
        logic bad;
        bad = 1'b1;
        case (f3)
            LB, LBU:  bad = 1'b0;
            LH, LHU:  bad = offs[0];
            LW:       bad = |offs[1:0];
            LWU:      bad = !rv64 || (|offs[1:0]);
            LD:       bad = !rv64 || (|offs);
            default:  bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/cpu_load_writeback_if.sv
// Bus between the memory stage / data memory (master) and the writeback
// stage (slave), including the register-file write port and status pulses.
interface cpu_load_writeback_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] alu_out;
    logic [XLEN-1:0] pc;
    logic [2:0]      funct3;
    logic [1:0]      wb_mux;
    logic [4:0]      rd_addr_in;
    logic            reg_write;
    logic            flush;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;
    logic            rd_we;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rd_data;
    logic            load_fault;
    logic            load_timeout;
    logic            busy;

    modport master (
        output in_valid, alu_out, pc, funct3, wb_mux, rd_addr_in, reg_write,
               flush, mem_rvalid, mem_rdata,
        input  in_ready, rd_we, rd_addr, rd_data, load_fault, load_timeout, busy
    );

    modport slave (
        input  in_valid, alu_out, pc, funct3, wb_mux, rd_addr_in, reg_write,
               flush, mem_rvalid, mem_rdata,
        output in_ready, rd_we, rd_addr, rd_data, load_fault, load_timeout, busy
    );
endinterface

// File: rtl/cpu_load_writeback_load_align_extend.sv
// Byte-lane alignment and sign/zero extension of raw load data. Purely
// combinational so it can be shared with a store/AMO path later.
module load_align_extend
    import cpu_load_writeback_pkg::*;
#(
    parameter  int XLEN   = 32,
    localparam int OFFS_W = $clog2(XLEN/8)
) (
    input  logic [XLEN-1:0]   data_i,
    input  logic [OFFS_W-1:0] offset_i,
    input  logic [2:0]        funct3_i,
    output logic [XLEN-1:0]   ext_o
);

    logic [XLEN-1:0] shifted;
    int              keep;
    logic            sext;
    logic            msb;

    // Shift the addressed bytes down to lane 0, then replace everything above
    // the access size with the sign bit (signed loads) or zero (unsigned).
    always_comb begin
        // NOTE: every variable assigned here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        shifted = data_i >> {offset_i, 3'b000};
        keep    = XLEN;
        sext    = 1'b0;
        msb     = 1'b0;
        case (funct3_i)
            LB:      begin keep = 8;  sext = 1'b1; msb = shifted[7];  end
            LBU:     begin keep = 8;  end
            LH:      begin keep = 16; sext = 1'b1; msb = shifted[15]; end
            LHU:     begin keep = 16; end
            LW:      begin keep = 32; sext = 1'b1; msb = shifted[31]; end
            LWU:     begin keep = 32; end
            default: begin keep = XLEN; end
        endcase
        ext_o = shifted;
        for (int i = 8; i < XLEN; i++) begin
            if (i >= keep) ext_o[i] = sext & msb;
        end
    end

endmodule

// File: rtl/cpu_load_writeback.sv
// Registered writeback stage: selects ALU result, PC+4 or aligned load data
// for the register file, waits for load responses with a timeout, and flags
// misaligned/illegal loads.
module cpu_load_writeback
    import cpu_load_writeback_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst,
    cpu_load_writeback_if.slave bus
);

    localparam int              OFFS_W   = $clog2(XLEN/8);
    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic            IS_RV64  = (XLEN == 64);

    wb_state_t         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // pending load context captured at accept time
    logic [2:0]        ld_f3_q, ld_f3_d;
    logic [OFFS_W-1:0] ld_off_q, ld_off_d;
    logic [4:0]        ld_rd_q, ld_rd_d;
    logic              ld_we_q, ld_we_d;

    // registered outputs
    logic              rd_we_q, rd_we_d;
    logic [4:0]        rd_addr_q, rd_addr_d;
    logic [XLEN-1:0]   rd_data_q, rd_data_d;
    logic              fault_q, fault_d;
    logic              timeout_q, timeout_d;

    logic [OFFS_W-1:0] req_off;
    logic [XLEN-1:0]   load_val;

    assign req_off = bus.alu_out[OFFS_W-1:0];

    load_align_extend #(.XLEN(XLEN)) u_align (
        .data_i   (bus.mem_rdata),
        .offset_i (ld_off_q),
        .funct3_i (ld_f3_q),
        .ext_o    (load_val)
    );

    // Next-state and output decode; pulses default low, data/address hold.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ld_f3_d   = ld_f3_q;
        ld_off_d  = ld_off_q;
        ld_rd_d   = ld_rd_q;
        ld_we_d   = ld_we_q;
        rd_we_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        rd_data_d = rd_data_q;
        fault_d   = 1'b0;
        timeout_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.in_valid && !bus.flush) begin
                    case (bus.wb_mux)
                        ALUOUT_SEL, PC_P_4_SEL: begin
                            if (bus.reg_write && (bus.rd_addr_in != 5'd0)) begin
                                rd_we_d   = 1'b1;
                                rd_addr_d = bus.rd_addr_in;
                                rd_data_d = (bus.wb_mux == ALUOUT_SEL) ?
                                            bus.alu_out : bus.pc + XLEN'(4);
                            end
                        end
                        DTAMEM_SEL: begin
                            if (load_is_faulty(bus.funct3, 3'(req_off), IS_RV64)) begin
                                fault_d = 1'b1;
                            end else begin
                                ld_f3_d  = bus.funct3;
                                ld_off_d = req_off;
                                ld_rd_d  = bus.rd_addr_in;
                                ld_we_d  = bus.reg_write;
                                cnt_d    = '0;
                                state_d  = WAIT;
                            end
                        end
                        default: ; // reserved select: retire without writing
                    endcase
                end
            end
            WAIT: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else if (bus.mem_rvalid) begin
                    if (ld_we_q && (ld_rd_q != 5'd0)) begin
                        rd_we_d   = 1'b1;
                        rd_addr_d = ld_rd_q;
                        rd_data_d = load_val;
                    end
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counter, pending-load and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ld_f3_q   <= 3'b000;
            ld_off_q  <= '0;
            ld_rd_q   <= 5'd0;
            ld_we_q   <= 1'b0;
            rd_we_q   <= 1'b0;
            rd_addr_q <= 5'd0;
            rd_data_q <= '0;
            fault_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ld_f3_q   <= ld_f3_d;
            ld_off_q  <= ld_off_d;
            ld_rd_q   <= ld_rd_d;
            ld_we_q   <= ld_we_d;
            rd_we_q   <= rd_we_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
            fault_q   <= fault_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.in_ready     = (state_q == IDLE);
    assign bus.busy         = (state_q == WAIT);
    assign bus.rd_we        = rd_we_q;
    assign bus.rd_addr      = rd_addr_q;
    assign bus.rd_data      = rd_data_q;
    assign bus.load_fault   = fault_q;
    assign bus.load_timeout = timeout_q;

endmodule
